// File: rtl/mm_job_sched.sv
// Matmul job scheduler: queues {mode,id} commands, launches them one at a
// time on the engine, counts tiles and returns one completion record per job.
module mm_job_sched #(
    parameter int QD    = 4,
    parameter int CNT_W = 16,
    parameter int AW    = $clog2(QD),
    parameter int LW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_mode,
    input  logic [3:0]       i_cmd_id,
    input  logic             i_flush,
    output logic             o_mm_start,
    output logic [1:0]       o_mm_mode,
    input  logic             i_tile_done,
    input  logic             i_mtrx_done,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic [3:0]       o_done_id,
    output logic [CNT_W-1:0] o_done_tiles,
    output logic             o_done_err,
    output logic [LW-1:0]    o_q_level,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        REPORT
    } state_t;

    state_t             state_q;
    logic [5:0]         mem_q [QD];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [LW-1:0]      level_d;
    logic [3:0]         id_q;
    logic [CNT_W-1:0]   tiles_q;
    logic               err_q;
    logic               start_q;
    logic [1:0]         mode_q;
    logic               full;
    logic               push;
    logic               pop;
    logic [5:0]         head;

    assign full        = (level_q == LW'(QD));
    assign o_cmd_ready = !full && !i_flush;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state_q == LAUNCH);
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (i_flush) begin
            level_d = '0;
        end else begin
            level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_cmd_mode, i_cmd_id};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            id_q     <= '0;
            tiles_q  <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            mode_q   <= '0;
        end else begin
            level_q <= level_d;
            start_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            // Flush empties the queue by catching the read pointer up.
            if (i_flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (level_q != '0 && !i_flush) begin
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    id_q    <= head[3:0];
                    tiles_q <= '0;
                    if (head[5:4] == 2'd3) begin
                        err_q   <= 1'b1;
                        state_q <= REPORT;
                    end else begin
                        err_q   <= 1'b0;
                        start_q <= 1'b1;
                        mode_q  <= head[5:4];
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (i_tile_done && tiles_q != '1) begin
                        tiles_q <= tiles_q + 1'b1;
                    end
                    if (i_mtrx_done) begin
                        state_q <= REPORT;
                    end
                end
                REPORT: begin
                    if (i_done_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mm_start   = start_q;
    assign o_mm_mode    = mode_q;
    assign o_done_valid = (state_q == REPORT);
    assign o_done_id    = id_q;
    assign o_done_tiles = tiles_q;
    assign o_done_err   = err_q;
    assign o_q_level    = level_q;
    assign o_busy       = (state_q != IDLE) || (level_q != '0);

endmodule
